// File: rtl/uart_mem_loader_pkg.sv
// Shared constants, state encodings and baud-rate helper for the UART memory loader.
package uart_mem_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4
    } frame_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // Clocks per UART bit, integer-truncated.
    function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_mem_loader_rx.sv
// 8N1 UART byte receiver with 2-flop input synchronizer and start-bit glitch rejection.
module uart_rx_byte
    import uart_mem_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ser_rx,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_ferr
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic             meta_q, sync_q, prev_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    // Receiver state and synchronizer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            meta_q  <= ser_rx;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Bit timing: confirm start at half a bit, then sample each bit mid-cell.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync_q) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    bit_d = '0;
                    state_d = sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d  = '0;
                    data_d = {sync_q, data_q[7:1]};
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    valid_d = sync_q;
                    ferr_d  = !sync_q;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_valid = valid_q;
    assign rx_data  = data_q;
    assign rx_ferr  = ferr_q;

endmodule

// File: rtl/uart_mem_loader.sv
// Framed serial image loader: parses A5/len/data/csum frames and writes 32-bit words to memory.
module uart_mem_loader
    import uart_mem_loader_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned MEM_WORDS    = 4096,
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned TIMEOUT_BITS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ser_rx,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int unsigned WC_W         = ADDR_W + 1;
    localparam logic [31:0] TMO_LAST     = 32'(TIMEOUT_BITS * CLKS_PER_BIT - 1);

    logic       rx_valid, rx_ferr;
    logic [7:0] rx_data;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk      (clk),
        .reset    (reset),
        .ser_rx   (ser_rx),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ferr  (rx_ferr)
    );

    frame_state_e      state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       word_q, word_d;
    logic [7:0]        csum_q, csum_d;
    logic [31:0]       tmo_q, tmo_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [15:0] len_n_c;
    logic        timeout_c;

    assign len_n_c   = {len_q[15:8], rx_data};
    assign timeout_c = (state_q != ST_IDLE) && !rx_valid && (tmo_q == TMO_LAST);

    // Frame FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            word_cnt_q  <= '0;
            byte_idx_q  <= '0;
            word_q      <= '0;
            csum_q      <= '0;
            tmo_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_cnt_q  <= word_cnt_d;
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            csum_q      <= csum_d;
            tmo_q       <= tmo_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Next-state: frame parsing, word assembly, checksum, timeout and abort handling.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_cnt_d  = word_cnt_q;
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        csum_d      = csum_q;
        tmo_d       = '0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_reset_d = cpu_reset_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;

        if (state_q != ST_IDLE && !rx_valid) tmo_d = tmo_q + 32'd1;

        if (state_q != ST_IDLE && (rx_ferr || timeout_c)) begin
            state_d     = ST_IDLE;
            err_d       = 1'b1;
            busy_d      = 1'b0;
            cpu_reset_d = 1'b1;
        end else if (rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d     = ST_LEN_HI;
                        done_d      = 1'b0;
                        err_d       = 1'b0;
                        busy_d      = 1'b1;
                        cpu_reset_d = 1'b1;
                        word_cnt_d  = '0;
                        byte_idx_d  = '0;
                        csum_d      = '0;
                    end
                end
                ST_LEN_HI: begin
                    len_d   = {rx_data, 8'h00};
                    state_d = ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    len_d = len_n_c;
                    if (len_n_c == 16'd0 || 32'(len_n_c) > MEM_WORDS) begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    word_d     = {rx_data, word_q[31:8]};
                    csum_d     = csum_q ^ rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = word_cnt_q[ADDR_W-1:0];
                        mem_wdata_d = {rx_data, word_q[31:8]};
                        word_cnt_d  = word_cnt_q + WC_W'(1);
                        if (32'(word_cnt_q) + 32'd1 == 32'(len_q)) state_d = ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                    if (rx_data == csum_q) begin
                        done_d      = 1'b1;
                        cpu_reset_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_reset = cpu_reset_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed bench for uart_mem_loader at 10 clocks per bit, 16-word memory.
module tb_uart_mem_loader;

    localparam int unsigned CPB = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        ser_rx;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset, busy, done, err;

    always #5 clk = ~clk;

    uart_mem_loader #(
        .CLK_HZ(1_000_000), .BAUD(100_000), .MEM_WORDS(16), .ADDR_W(4), .TIMEOUT_BITS(32)
    ) dut (
        .clk(clk), .reset(reset), .ser_rx(ser_rx),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err)
    );

    int n_vec = 0;
    int n_miss = 0;

    int cyc = 0, vcyc = 0, nvalid = 0, wcnt = 0, wlat_bad = 0, fall_lat = -1;
    logic        cpu_reset_prev = 1'b1;
    logic [31:0] mem_m [16];

    // Memory model and write/cpu_reset timing relative to the receiver's byte strobe.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (mem_we === 1'b1) begin
            mem_m[mem_addr] = mem_wdata;
            wcnt = wcnt + 1;
            if (cyc - vcyc != 1) wlat_bad = wlat_bad + 1;
        end
        if (cpu_reset_prev === 1'b1 && cpu_reset === 1'b0) fall_lat = cyc - vcyc;
        cpu_reset_prev = cpu_reset;
        if (dut.u_rx.rx_valid === 1'b1) begin
            vcyc = cyc;
            nvalid = nvalid + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        ser_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ser_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        ser_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        ser_rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic sb(input logic [7:0] b);
        send_byte(b, 1'b1);
    endtask

    // Two-word program: [0]=0x00000513, [1]=0xC0001073; XOR of its data bytes is 0xB5.
    task automatic two_word_frame(input logic [7:0] csum);
        sb(8'hA5); sb(8'h00); sb(8'h02);
        sb(8'h13); sb(8'h05); sb(8'h00); sb(8'h00);
        sb(8'h73); sb(8'h10); sb(8'h00); sb(8'hC0);
        sb(csum);
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_we"},    32'(mem_we),    32'd0);
        chk({pfx, "_addr"},  32'(mem_addr),  32'd0);
        chk({pfx, "_wdata"}, mem_wdata,      32'd0);
        chk({pfx, "_cpurst"},32'(cpu_reset), 32'd1);
        chk({pfx, "_busy"},  32'(busy),      32'd0);
        chk({pfx, "_done"},  32'(done),      32'd0);
        chk({pfx, "_err"},   32'(err),       32'd0);
    endtask

    initial begin
        int nv;
        ser_rx = 1'b1;
        reset  = 1'b1;
        for (int i = 0; i < 16; i++) mem_m[i] = 32'd0;
        repeat (5) @(negedge clk);
        chk_reset_vals("por");
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // Good frame
        wcnt = 0;
        two_word_frame(8'hB5);
        chk("good_wcnt",   32'(wcnt), 32'd2);
        chk("good_w0",     mem_m[0], 32'h0000_0513);
        chk("good_w1",     mem_m[1], 32'hC000_1073);
        chk("good_done",   32'(done), 32'd1);
        chk("good_err",    32'(err), 32'd0);
        chk("good_busy",   32'(busy), 32'd0);
        chk("good_cpurst", 32'(cpu_reset), 32'd0);
        chk("good_fall_lat", 32'(fall_lat), 32'd1);
        chk("good_we_lat", 32'(wlat_bad), 32'd0);

        // Bad checksum
        wcnt = 0;
        for (int i = 0; i < 16; i++) mem_m[i] = 32'd0;
        two_word_frame(8'h00);
        chk("badcs_wcnt",   32'(wcnt), 32'd2);
        chk("badcs_w1",     mem_m[1], 32'hC000_1073);
        chk("badcs_err",    32'(err), 32'd1);
        chk("badcs_done",   32'(done), 32'd0);
        chk("badcs_cpurst", 32'(cpu_reset), 32'd1);

        // Length zero
        wcnt = 0;
        sb(8'hA5);
        chk("len0_err_clr", 32'(err), 32'd0);
        chk("len0_busy_set", 32'(busy), 32'd1);
        sb(8'h00); sb(8'h00);
        chk("len0_err",  32'(err), 32'd1);
        chk("len0_busy", 32'(busy), 32'd0);

        // Length 17 exceeds the 16-word memory
        sb(8'hA5); sb(8'h00); sb(8'h11);
        sb(8'h01); sb(8'h02); sb(8'h03); sb(8'h04);
        chk("len17_err",  32'(err), 32'd1);
        chk("len17_wcnt", 32'(wcnt), 32'd0);

        // Full 16-word frame; data byte j = j, so the checksum of 0..63 is 0x00
        wcnt = 0;
        for (int i = 0; i < 16; i++) mem_m[i] = 32'd0;
        sb(8'hA5); sb(8'h00); sb(8'h10);
        for (int j = 0; j < 64; j++) sb(8'(j));
        sb(8'h00);
        chk("n16_wcnt", 32'(wcnt), 32'd16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("n16_w%0d", i), mem_m[i],
                {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
        chk("n16_done", 32'(done), 32'd1);
        chk("n16_we_lat", 32'(wlat_bad), 32'd0);

        // Short glitch on idle line
        nv = nvalid;
        @(negedge clk);
        ser_rx = 1'b0;
        repeat (3) @(negedge clk);
        ser_rx = 1'b1;
        repeat (60) @(negedge clk);
        chk("glitch_nbytes", 32'(nvalid), 32'(nv));
        chk("glitch_done",   32'(done), 32'd1);
        chk("glitch_busy",   32'(busy), 32'd0);

        // Framing error on LEN_LO
        sb(8'hA5); sb(8'h00);
        send_byte(8'h04, 1'b0);
        chk("ferr_err",   32'(err), 32'd1);
        chk("ferr_busy",  32'(busy), 32'd0);
        chk("ferr_state", 32'(dut.state_q), 32'd0);

        // Timeout after two data bytes
        wcnt = 0;
        sb(8'hA5); sb(8'h00); sb(8'h01); sb(8'h13); sb(8'h05);
        chk("tmo_busy_pre", 32'(busy), 32'd1);
        chk("tmo_err_pre",  32'(err), 32'd0);
        repeat (330) @(negedge clk);
        chk("tmo_err",    32'(err), 32'd1);
        chk("tmo_busy",   32'(busy), 32'd0);
        chk("tmo_cpurst", 32'(cpu_reset), 32'd1);
        chk("tmo_wcnt",   32'(wcnt), 32'd0);

        // Reset mid-DATA, then recover with a good frame
        wcnt = 0;
        sb(8'hA5); sb(8'h00); sb(8'h02); sb(8'h13); sb(8'h05); sb(8'h00);
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("midrst");
        chk("midrst_wcnt", 32'(wcnt), 32'd0);
        for (int i = 0; i < 16; i++) mem_m[i] = 32'd0;
        two_word_frame(8'hB5);
        chk("recov_wcnt", 32'(wcnt), 32'd2);
        chk("recov_w0",   mem_m[0], 32'h0000_0513);
        chk("recov_w1",   mem_m[1], 32'hC000_1073);
        chk("recov_done", 32'(done), 32'd1);

        // Reload: stray byte ignored, then new frame overwrites word 0 (csum EF^BE^AD^DE = 0x22)
        wcnt = 0;
        sb(8'h55);
        chk("stray_done",   32'(done), 32'd1);
        chk("stray_busy",   32'(busy), 32'd0);
        chk("stray_cpurst", 32'(cpu_reset), 32'd0);
        sb(8'hA5);
        chk("reload_cpurst", 32'(cpu_reset), 32'd1);
        chk("reload_done",   32'(done), 32'd0);
        chk("reload_busy",   32'(busy), 32'd1);
        sb(8'h00); sb(8'h01);
        sb(8'hEF); sb(8'hBE); sb(8'hAD); sb(8'hDE);
        sb(8'h22);
        chk("reload_wcnt",   32'(wcnt), 32'd1);
        chk("reload_w0",     mem_m[0], 32'hDEAD_BEEF);
        chk("reload_done2",  32'(done), 32'd1);
        chk("reload_cpurst2",32'(cpu_reset), 32'd0);
        chk("final_we_lat",  32'(wlat_bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
